// File: rtl/ws2812_rx.sv
// WS2812/NeoPixel receiver: measures high/low pulse widths on a synchronized
// data line, assembles 24-bit pixels and reports frame status at each latch.
module ws2812_rx #(
  parameter int unsigned NUM_LEDS     = 8,
  parameter int unsigned SYSTEM_CLOCK = 50000000,
  parameter int unsigned T_THRESH_NS  = 600,
  parameter int unsigned T_GLITCH_NS  = 100,
  parameter int unsigned T_MAXH_NS    = 2000,
  parameter int unsigned T_RESET_NS   = 50000
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        di_i,
  output logic                        pix_valid_o,
  output logic [23:0]                 pix_data_o,
  output logic [$clog2(NUM_LEDS)-1:0] pix_addr_o,
  output logic                        busy_o,
  output logic                        frame_done_o,
  output logic [$clog2(NUM_LEDS):0]   frame_len_o,
  output logic                        frame_ovf_o,
  output logic                        frame_err_o,
  output logic                        err_o
);
  localparam int unsigned CLK_MHZ    = SYSTEM_CLOCK / 1000000;
  localparam int unsigned THRESH_CYC = CLK_MHZ * T_THRESH_NS / 1000;
  localparam int unsigned GLITCH_CYC = CLK_MHZ * T_GLITCH_NS / 1000;
  localparam int unsigned MAXH_CYC   = CLK_MHZ * T_MAXH_NS / 1000;
  localparam int unsigned RESET_CYC  = CLK_MHZ * T_RESET_NS / 1000;
  localparam int unsigned CW         = $clog2(RESET_CYC + 1);
  localparam int unsigned AW         = $clog2(NUM_LEDS);
  localparam int unsigned LW         = AW + 1;

  typedef enum logic [1:0] {S_SYNC, S_IDLE, S_HIGH, S_LOW} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sync1, sync2, prev;
  logic            rise, fall;
  logic            start, shift_en, abort, latch, sync_done;
  logic [4:0]      bitcnt;
  logic [23:0]     shifter;
  logic [LW-1:0]   addr;
  logic            ovf, err;

  assign rise = sync2 & ~prev;
  assign fall = ~sync2 & prev;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_q <= S_SYNC;
    else            state_q <= state_d;
  end

  // One counter serves as SYNC low-run, HIGH width and LOW width; the states are exclusive.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    start     = 1'b0;
    shift_en  = 1'b0;
    abort     = 1'b0;
    latch     = 1'b0;
    sync_done = 1'b0;
    unique case (state_q)
      S_SYNC: begin
        if (sync2) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(RESET_CYC - 1)) begin
          cnt_d     = '0;
          sync_done = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_IDLE: begin
        if (rise) begin
          start   = 1'b1;
          cnt_d   = CW'(1);
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (fall) begin
          if (cnt_q < CW'(GLITCH_CYC)) begin
            abort   = 1'b1;
            cnt_d   = '0;
            state_d = S_SYNC;
          end else begin
            shift_en = 1'b1;
            cnt_d    = CW'(1);
            state_d  = S_LOW;
          end
        end else if (cnt_q == CW'(MAXH_CYC - 1)) begin
          abort   = 1'b1;
          cnt_d   = '0;
          state_d = S_SYNC;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LOW: begin
        if (rise) begin
          cnt_d   = CW'(1);
          state_d = S_HIGH;
        end else if (cnt_q == CW'(RESET_CYC - 1)) begin
          latch   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cnt_q        <= '0;
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      prev         <= 1'b0;
      bitcnt       <= '0;
      shifter      <= '0;
      addr         <= '0;
      ovf          <= 1'b0;
      err          <= 1'b0;
      pix_valid_o  <= 1'b0;
      pix_data_o   <= '0;
      pix_addr_o   <= '0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      frame_len_o  <= '0;
      frame_ovf_o  <= 1'b0;
      frame_err_o  <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sync1        <= di_i;
      sync2        <= sync1;
      prev         <= sync2;
      pix_valid_o  <= 1'b0;
      frame_done_o <= 1'b0;
      err_o        <= 1'b0;

      if (start) begin
        busy_o <= 1'b1;
        addr   <= '0;
        ovf    <= 1'b0;
        err    <= 1'b0;
        bitcnt <= '0;
      end

      if (shift_en) begin
        shifter <= {shifter[22:0], (cnt_q >= CW'(THRESH_CYC))};
        bitcnt  <= bitcnt + 5'd1;
      end

      if (bitcnt == 5'd24) begin
        bitcnt <= '0;
        if (addr < LW'(NUM_LEDS)) begin
          pix_valid_o <= 1'b1;
          pix_data_o  <= shifter;
          pix_addr_o  <= addr[AW-1:0];
          addr        <= addr + LW'(1);
        end else begin
          ovf <= 1'b1;
        end
      end

      if (abort) begin
        err_o <= 1'b1;
        err   <= 1'b1;
      end

      // An aborted frame is closed when SYNC completes; a clean one at the latch.
      if (latch || (sync_done && busy_o)) begin
        frame_done_o <= 1'b1;
        frame_len_o  <= addr;
        frame_ovf_o  <= ovf;
        frame_err_o  <= err | (latch && (bitcnt != 5'd0));
        busy_o       <= 1'b0;
        addr         <= '0;
        bitcnt       <= '0;
        if (latch && (bitcnt != 5'd0)) err_o <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: a pulse-level protocol model predicts pixels, frames and
// error strobes; directed scenarios plus randomized frames are checked against it.
module tb_ws2812_rx;
  localparam int unsigned NUM_LEDS = 8;
  localparam int GLITCH = 5;
  localparam int THRESH = 30;
  localparam int MAXH   = 100;
  localparam int RESETC = 2500;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        di = 1'b0;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic [2:0]  pix_addr;
  logic        busy;
  logic        frame_done;
  logic [3:0]  frame_len;
  logic        frame_ovf;
  logic        frame_err;
  logic        err;

  ws2812_rx #(
    .NUM_LEDS    (NUM_LEDS),
    .SYSTEM_CLOCK(50000000),
    .T_THRESH_NS (600),
    .T_GLITCH_NS (100),
    .T_MAXH_NS   (2000),
    .T_RESET_NS  (50000)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .di_i        (di),
    .pix_valid_o (pix_valid),
    .pix_data_o  (pix_data),
    .pix_addr_o  (pix_addr),
    .busy_o      (busy),
    .frame_done_o(frame_done),
    .frame_len_o (frame_len),
    .frame_ovf_o (frame_ovf),
    .frame_err_o (frame_err),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; logic [23:0] data; } pix_t;
  typedef struct { int len; bit ovf; bit err; } frm_t;

  int tests = 0;
  int fails = 0;
  pix_t exp_pix[$];
  frm_t exp_frm[$];
  int exp_errs = 0;
  int seen_errs = 0;
  int n_pix = 0;
  int n_frames = 0;
  int last_addr = -1;
  logic [23:0] last_data = '0;
  int last_len = -1;
  bit last_ovf, last_err;

  bit m_sync, m_frame, m_ovf, m_err;
  int m_low, m_bits, m_npix;
  logic [23:0] m_word;

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_sync = 1; m_frame = 0; m_low = 0; m_bits = 0; m_npix = 0;
    m_ovf = 0; m_err = 0; m_word = '0;
  endtask

  task automatic model_low(input int n);
    m_low += n;
    if (m_low >= RESETC) begin
      if (m_sync) begin
        m_sync = 0;
        if (m_frame) begin
          exp_frm.push_back('{m_npix, m_ovf, 1'b1});
          m_frame = 0;
        end
      end else if (m_frame) begin
        if (m_bits != 0) begin exp_errs++; m_err = 1; end
        exp_frm.push_back('{m_npix, m_ovf, m_err});
        m_frame = 0;
      end
    end
  endtask

  task automatic model_high(input int n);
    m_low = 0;
    if (!m_sync) begin
      if (!m_frame) begin
        m_frame = 1; m_npix = 0; m_ovf = 0; m_err = 0; m_bits = 0;
      end
      if (n < GLITCH || n >= MAXH) begin
        exp_errs++; m_err = 1; m_sync = 1;
      end else begin
        m_word = {m_word[22:0], (n >= THRESH)};
        m_bits++;
        if (m_bits == 24) begin
          if (m_npix < NUM_LEDS) begin
            exp_pix.push_back('{m_npix, m_word});
            m_npix++;
          end else begin
            m_ovf = 1;
          end
          m_bits = 0;
        end
      end
    end
  endtask

  task automatic drive(input logic v, input int n);
    di = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_high(input int n); model_high(n); drive(1'b1, n); endtask
  task automatic send_low(input int n);  model_low(n);  drive(1'b0, n); endtask

  task automatic send_bit_std(input bit b);
    if (b) begin send_high(40); send_low(20); end
    else   begin send_high(17); send_low(45); end
  endtask

  task automatic send_pixel_std(input logic [23:0] d);
    for (int i = 23; i >= 0; i--) send_bit_std(d[i]);
  endtask

  task automatic send_bit_rand(input bit b);
    send_high(b ? int'($urandom_range(99, 30)) : int'($urandom_range(29, 5)));
    send_low(int'($urandom_range(20, 2)));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_pix_valid"}, pix_valid, 0);
    check({tag, "_pix_data"}, pix_data, 0);
    check({tag, "_pix_addr"}, pix_addr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_frame_len"}, frame_len, 0);
    check({tag, "_frame_ovf"}, frame_ovf, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic monitor();
    pix_t p;
    frm_t f;
    forever begin
      @(negedge clk);
      if (pix_valid) begin
        n_pix++;
        last_addr = int'(pix_addr);
        last_data = pix_data;
        check("busy_with_pixel", busy, 1);
        check("done_with_pixel", frame_done, 0);
        if (exp_pix.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_pixel: got addr %0d data 0x%06h, required no strobe", pix_addr, pix_data);
        end else begin
          p = exp_pix.pop_front();
          check("pix_addr", pix_addr, p.addr);
          check("pix_data", pix_data, p.data);
        end
      end
      if (frame_done) begin
        n_frames++;
        last_len = int'(frame_len);
        last_ovf = frame_ovf;
        last_err = frame_err;
        check("busy_at_done", busy, 0);
        if (exp_frm.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_frame_done: got len %0d, required no strobe", frame_len);
        end else begin
          f = exp_frm.pop_front();
          check("frame_len", frame_len, f.len);
          check("frame_ovf", frame_ovf, f.ovf);
          check("frame_err", frame_err, f.err);
        end
      end
      if (err) seen_errs++;
    end
  endtask

  initial begin
    int p0, f0, e0, npx;
    int bw[4];
    logic [23:0] d;
    bw[0] = 5; bw[1] = 29; bw[2] = 30; bw[3] = 99;

    fork monitor(); join_none

    model_reset();
    reset_n = 1'b0; di = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_zero_outputs("reset");
    send_low(2600);

    // Single pixel 0xFF0055
    p0 = n_pix; f0 = n_frames;
    send_pixel_std(24'hFF0055);
    check("t1_busy_in_frame", busy, 1);
    send_low(2600);
    check("t1_pix_count", n_pix - p0, 1);
    check("t1_data", last_data, 24'hFF0055);
    check("t1_addr", last_addr, 0);
    check("t1_frames", n_frames - f0, 1);
    check("t1_len", last_len, 1);
    check("t1_ovf", last_ovf, 0);
    check("t1_err", last_err, 0);

    // Ten pixels into an eight-entry frame
    p0 = n_pix; f0 = n_frames;
    for (int k = 1; k <= 10; k++) send_pixel_std(24'(k));
    send_low(2600);
    check("t2_pix_count", n_pix - p0, 8);
    check("t2_last_data", last_data, 24'h000008);
    check("t2_last_addr", last_addr, 7);
    check("t2_len", last_len, 8);
    check("t2_ovf", last_ovf, 1);
    check("t2_err", last_err, 0);

    // Partial pixel (12 bits) closed by the latch
    p0 = n_pix; f0 = n_frames; e0 = seen_errs;
    for (int i = 0; i < 12; i++) send_bit_std(i[0]);
    send_low(2600);
    check("t3_pix_count", n_pix - p0, 0);
    check("t3_errs", seen_errs - e0, 1);
    check("t3_frames", n_frames - f0, 1);
    check("t3_len", last_len, 0);
    check("t3_err", last_err, 1);

    // Pixel followed by a 3-cycle glitch
    p0 = n_pix; f0 = n_frames; e0 = seen_errs;
    send_pixel_std(24'h5A3C96);
    send_high(3);
    send_low(100);
    check("t4_busy_in_sync", busy, 1);
    send_low(2500);
    check("t4_pix_count", n_pix - p0, 1);
    check("t4_errs", seen_errs - e0, 1);
    check("t4_frames", n_frames - f0, 1);
    check("t4_len", last_len, 1);
    check("t4_err", last_err, 1);

    // Mid-frame join: reset with the line high, then traffic without a latch
    p0 = n_pix; f0 = n_frames;
    di = 1'b1; reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 30; i++) send_bit_rand(1'($urandom));
    check("t5_busy", busy, 0);
    check("t5_pix_count", n_pix - p0, 0);
    send_low(2600);
    check("t5_busy_after_latch", busy, 0);
    check("t5_frames", n_frames - f0, 0);

    // Reset pulse after two of three pixels
    p0 = n_pix; f0 = n_frames;
    send_pixel_std(24'h123456);
    send_pixel_std(24'hABCDEF);
    send_low(30);
    check("t6_pix_before_reset", n_pix - p0, 2);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    check_zero_outputs("t6_reset");
    send_pixel_std(24'h777777);
    send_low(2600);
    check("t6_no_done_after_reset", n_frames - f0, 0);
    check("t6_no_pix_after_reset", n_pix - p0, 2);
    send_pixel_std(24'h010203);
    send_pixel_std(24'h040506);
    send_pixel_std(24'h070809);
    send_low(2600);
    check("t6_pix_count", n_pix - p0, 5);
    check("t6_last_addr", last_addr, 2);
    check("t6_last_data", last_data, 24'h070809);
    check("t6_len", last_len, 3);
    check("t6_err", last_err, 0);

    // Randomized frames; frame 1 uses boundary widths, frame 2 ends on an over-long high
    for (int fr = 0; fr < 3; fr++) begin
      npx = int'($urandom_range(4, 1));
      for (int px = 0; px < npx; px++) begin
        d = 24'($urandom);
        for (int i = 23; i >= 0; i--) begin
          if (fr == 1) begin
            send_high(bw[$urandom_range(3, 0)]);
            send_low(int'($urandom_range(20, 2)));
          end else begin
            send_bit_rand(d[i]);
          end
        end
      end
      if (fr == 2) send_high(MAXH);
      send_low(2600);
    end

    check("pix_queue_drained", exp_pix.size(), 0);
    check("frame_queue_drained", exp_frm.size(), 0);
    check("err_strobe_count", seen_errs, exp_errs);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
